// File: rtl/alu_sequencer_pkg.sv
// Shared opcodes, FSM states and default sizing for the ALU sequencer.
package alu_sequencer_pkg;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_ADDR_W = 2;
   localparam int DEF_NREGS  = 1 << DEF_ADDR_W;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_LDI = 2'b10,
      OP_MOV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_DONE = 2'b10
   } state_e;

   function automatic logic is_arith(op_e op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// Register file: one write port, three combinational read ports.
module alu_sequencer_regfile #(
   parameter int WIDTH  = 4,
   parameter int NREGS  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] ra1,
   output logic [WIDTH-1:0]  rd1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [WIDTH-1:0]  rd2,
   input  logic [ADDR_W-1:0] ra3,
   output logic [WIDTH-1:0]  rd3
);

   logic [WIDTH-1:0] mem [NREGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rd1 = mem[ra1];
   assign rd2 = mem[ra2];
   assign rd3 = mem[ra3];

endmodule

// File: rtl/alu_sequencer.sv
// Handshaked three-cycle sequencer wrapped around an external add/sub ALU.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NREGS  = DEF_NREGS,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic [ADDR_W-1:0] cmd_rs1,
   input  logic [ADDR_W-1:0] cmd_rs2,
   input  logic [WIDTH-1:0]  cmd_imm,
   output logic [WIDTH-1:0]  alu_in1,
   output logic [WIDTH-1:0]  alu_in2,
   output logic              alu_s,
   input  logic [WIDTH-1:0]  alu_out,
   output logic              done,
   output logic [WIDTH-1:0]  result,
   output logic              zero,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [WIDTH-1:0]  dbg_data
);

   state_e             state;
   op_e                op_q;
   logic [ADDR_W-1:0]  rd_q;
   logic [WIDTH-1:0]   imm_q;
   logic [WIDTH-1:0]   rs1_val;
   logic [WIDTH-1:0]   rs2_val;
   logic [WIDTH-1:0]   wb_data;
   logic               wb_en;

   assign cmd_ready = (state == S_IDLE);
   assign wb_en     = (state == S_EXEC);

   alu_sequencer_regfile #(
      .WIDTH  (WIDTH),
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .we    (wb_en),
      .waddr (rd_q),
      .wdata (wb_data),
      .ra1   (cmd_rs1),
      .rd1   (rs1_val),
      .ra2   (cmd_rs2),
      .rd2   (rs2_val),
      .ra3   (dbg_addr),
      .rd3   (dbg_data)
   );

   // alu_in1 doubles as the latched rs1 value that MOV writes back.
   always_comb begin
      wb_data = alu_out;
      unique case (1'b1)
         op_q == OP_LDI: wb_data = imm_q;
         op_q == OP_MOV: wb_data = alu_in1;
         default:        wb_data = alu_out;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         op_q    <= OP_ADD;
         rd_q    <= '0;
         imm_q   <= '0;
         alu_in1 <= '0;
         alu_in2 <= '0;
         alu_s   <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         zero    <= 1'b1;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q    <= op_e'(cmd_op);
                  rd_q    <= cmd_rd;
                  imm_q   <= cmd_imm;
                  alu_in1 <= rs1_val;
                  alu_in2 <= rs2_val;
                  alu_s   <= is_arith(op_e'(cmd_op)) & cmd_op[0];
                  state   <= S_EXEC;
               end
            end
            S_EXEC: begin
               result <= wb_data;
               zero   <= (wb_data == '0);
               done   <= 1'b1;
               state  <= S_DONE;
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
